// File: rtl/gpr_rf_sb_pkg.sv
// Shared constants and helpers for the GPR file with integrated scoreboard.
// Default geometry matches RV32I; index 0 is the hardwired-zero register.
package gpr_rf_sb_pkg;

    localparam int GPR_ADDR_W = 5;
    localparam int GPR_DATA_W = 32;
    localparam int ZERO_IDX   = 0;

    // LSB of port `port` inside a bus that packs ports of `width` bits each
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/gpr_rf_sb_if.sv
// Bundle of read, write, issue and debug signals between the pipeline and the GPR file.
// The master side drives indices, enables and data; the slave side returns data and hazard state.
interface gpr_rf_sb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_READ    = 2,
    parameter int NR_WRITE   = 2
);

    logic [NR_READ*ADDR_WIDTH-1:0]            raddr;
    logic [NR_READ*DATA_WIDTH-1:0]            rdata;
    logic [NR_READ-1:0]                       rbusy;
    logic [NR_WRITE-1:0]                      wen;
    logic [NR_WRITE*ADDR_WIDTH-1:0]           waddr;
    logic [NR_WRITE*DATA_WIDTH-1:0]           wdata;
    logic                                     iss_valid;
    logic [ADDR_WIDTH-1:0]                    iss_rd;
    logic                                     iss_ready;
    logic [ADDR_WIDTH:0]                      busy_cnt;
    logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]    dbg_regs;

    modport master (
        output raddr, wen, waddr, wdata, iss_valid, iss_rd,
        input  rdata, rbusy, iss_ready, busy_cnt, dbg_regs
    );

    modport slave (
        input  raddr, wen, waddr, wdata, iss_valid, iss_rd,
        output rdata, rbusy, iss_ready, busy_cnt, dbg_regs
    );

endinterface

// File: rtl/gpr_rf_sb_scoreboard.sv
// Per-register busy bits for outstanding writebacks, issue acceptance and busy popcount.
// A reservation and a writeback hitting the same register on one edge leaves it busy.
module gpr_rf_sb_scoreboard
    import gpr_rf_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = GPR_ADDR_W,
    parameter int NR_WRITE   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NR_WRITE-1:0]            i_wen,
    input  logic [NR_WRITE*ADDR_WIDTH-1:0] i_waddr,
    input  logic                           i_iss_valid,
    input  logic [ADDR_WIDTH-1:0]          i_iss_rd,
    output logic [(2**ADDR_WIDTH)-1:0]     o_busy,
    output logic                           o_iss_ready,
    output logic [ADDR_WIDTH:0]            o_busy_cnt
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [DEPTH-1:0] r_busy;
    logic [CNT_W-1:0] r_busy_cnt;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_iss_zero;

    // Issue acceptance from registered busy state only, so a writeback never shortcuts a WAW stall
    always_comb begin
        w_iss_zero  = (ZERO_REG != 0) && (i_iss_rd == ADDR_WIDTH'(ZERO_IDX));
        o_iss_ready = !r_busy[i_iss_rd] || w_iss_zero;
    end

    // Next busy vector with set-over-clear priority, and its popcount
    always_comb begin
        w_set      = '0;
        w_clr      = '0;
        w_busy_nxt = '0;
        w_cnt_nxt  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_set[k] = i_iss_valid && o_iss_ready && (i_iss_rd == ADDR_WIDTH'(k));
            for (int p = 0; p < NR_WRITE; p++) begin
                w_clr[k] = w_clr[k] |
                           (i_wen[p] && (i_waddr[port_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(k)));
            end
            if ((ZERO_REG != 0) && (k == ZERO_IDX)) begin
                w_busy_nxt[k] = 1'b0;
            end else if (w_set[k]) begin
                w_busy_nxt[k] = 1'b1;
            end else if (w_clr[k]) begin
                w_busy_nxt[k] = 1'b0;
            end else begin
                w_busy_nxt[k] = r_busy[k];
            end
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_busy_nxt[k]);
        end
    end

    // Busy vector and count registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/gpr_rf_sb.sv
// Multi-port general-purpose register file with write->read bypass and a writeback scoreboard.
// Reads are combinational; writes land on the clock edge, the highest write port winning on a clash.
module gpr_rf_sb
    import gpr_rf_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = GPR_ADDR_W,
    parameter int DATA_WIDTH = GPR_DATA_W,
    parameter int NR_READ    = 2,
    parameter int NR_WRITE   = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    gpr_rf_sb_if.slave   bus
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]         r_rf [DEPTH];
    logic [DEPTH-1:0]              w_busy;
    logic                          w_iss_ready;
    logic [ADDR_WIDTH:0]           w_busy_cnt;
    logic [ADDR_WIDTH-1:0]         w_ra [NR_READ];
    logic [NR_READ-1:0]            w_hit;
    logic [NR_READ*DATA_WIDTH-1:0] w_rdata;
    logic [NR_READ-1:0]            w_rbusy;
    logic [DEPTH*DATA_WIDTH-1:0]   w_dbg;

    gpr_rf_sb_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NR_WRITE   (NR_WRITE),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wen       (bus.wen),
        .i_waddr     (bus.waddr),
        .i_iss_valid (bus.iss_valid),
        .i_iss_rd    (bus.iss_rd),
        .o_busy      (w_busy),
        .o_iss_ready (w_iss_ready),
        .o_busy_cnt  (w_busy_cnt)
    );

    // Register storage; later ports are applied last so the younger write wins
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_rf[k] <= '0;
            end
        end else begin
            for (int p = 0; p < NR_WRITE; p++) begin
                if (bus.wen[p] &&
                    !((ZERO_REG != 0) &&
                      (bus.waddr[port_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(ZERO_IDX)))) begin
                    r_rf[bus.waddr[port_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH]] <=
                        bus.wdata[port_lsb(p, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

    // Read ports: storage, overridden by same-cycle writes (highest port last), x0 forced to zero
    always_comb begin
        w_rdata = '0;
        w_rbusy = '0;
        w_hit   = '0;
        for (int i = 0; i < NR_READ; i++) begin
            w_ra[i] = bus.raddr[port_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
            w_rdata[port_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = r_rf[w_ra[i]];
            for (int p = 0; p < NR_WRITE; p++) begin
                if ((BYPASS != 0) && bus.wen[p] &&
                    (bus.waddr[port_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH] == w_ra[i])) begin
                    w_hit[i] = 1'b1;
                    w_rdata[port_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
                        bus.wdata[port_lsb(p, DATA_WIDTH) +: DATA_WIDTH];
                end else begin
                    w_hit[i] = w_hit[i];
                end
            end
            if ((ZERO_REG != 0) && (w_ra[i] == ADDR_WIDTH'(ZERO_IDX))) begin
                w_rdata[port_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = '0;
                w_rbusy[i] = 1'b0;
            end else begin
                w_rbusy[i] = w_busy[w_ra[i]] && !w_hit[i];
            end
        end
    end

    // Flattened register image for the external register mirror
    always_comb begin
        w_dbg = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_dbg[port_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = r_rf[k];
        end
    end

    assign bus.rdata     = w_rdata;
    assign bus.rbusy     = w_rbusy;
    assign bus.iss_ready = w_iss_ready;
    assign bus.busy_cnt  = w_busy_cnt;
    assign bus.dbg_regs  = w_dbg;

endmodule
